// File: rtl/phy_cfg_pkg.sv
// Shared definitions for the PHY bring-up sequencer: MDIO register map,
// bit positions of interest and the one-hot state index enum.
package phy_cfg_pkg;

  localparam logic [4:0] REG_BMCR   = 5'd0;
  localparam logic [4:0] REG_BMSR   = 5'd1;
  localparam logic [4:0] REG_PHYID1 = 5'd2;
  localparam logic [4:0] REG_PHYID2 = 5'd3;

  localparam int BMCR_LOOPBACK_BIT = 14;
  localparam int BMSR_LINK_BIT     = 2;

  localparam int NUM_STATES = 11;

  // Bit position of each state inside the one-hot state vector
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WR_BMCR = 4'd1,
    ST_W_BMCR  = 4'd2,
    ST_RD_ID1  = 4'd3,
    ST_W_ID1   = 4'd4,
    ST_RD_ID2  = 4'd5,
    ST_W_ID2   = 4'd6,
    ST_RD_BMSR = 4'd7,
    ST_W_BMSR  = 4'd8,
    ST_DONE    = 4'd9,
    ST_ERR     = 4'd10
  } state_idx_e;

  typedef logic [NUM_STATES-1:0] state_vec_t;

  function automatic state_vec_t state_bit(input state_idx_e idx);
    state_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic is_onehot(input state_vec_t v);
    return (v != '0) && ((v & (v - state_vec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/mdio_cmd_issuer.sv
// Single MDIO transaction engine: waits out mdio_busy, emits a one-cycle
// command strobe with registered fields, then times the wait for mdio_ack.
module mdio_cmd_issuer
  import phy_cfg_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR    = 5'd1,
  parameter int         ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_req,
  input  logic        wait_req,
  input  logic        cmd_read,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  input  logic        mdio_busy,
  input  logic        mdio_ack,
  output logic        issue_fire,
  output logic        ack_seen,
  output logic        ack_timeout,
  output logic        mdio_cmd_valid,
  output logic        mdio_cmd_read,
  output logic [4:0]  mdio_cmd_phy,
  output logic [4:0]  mdio_cmd_reg,
  output logic [15:0] mdio_cmd_wdata
);

  localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic             valid_reg;
  logic             read_reg;
  logic [4:0]       phy_reg;
  logic [4:0]       reg_addr_reg;
  logic [15:0]      wdata_reg;
  logic [CNT_W-1:0] wait_cnt_reg;

  assign issue_fire  = issue_req & ~mdio_busy;
  assign ack_seen    = wait_req & mdio_ack;
  // Counter starts at 0 on the fire edge, so CNT_LAST lands the error
  // exactly ACK_TIMEOUT cycles after the strobe.
  assign ack_timeout = wait_req & ~mdio_ack & (wait_cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      read_reg     <= 1'b0;
      phy_reg      <= '0;
      reg_addr_reg <= '0;
      wdata_reg    <= '0;
      wait_cnt_reg <= '0;
    end else begin
      valid_reg <= issue_fire;
      if (issue_fire) begin
        read_reg     <= cmd_read;
        phy_reg      <= PHY_ADDR;
        reg_addr_reg <= cmd_reg_addr;
        wdata_reg    <= cmd_wdata;
        wait_cnt_reg <= '0;
      end else if (wait_req && (wait_cnt_reg != CNT_LAST)) begin
        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign mdio_cmd_valid = valid_reg;
  assign mdio_cmd_read  = read_reg;
  assign mdio_cmd_phy   = phy_reg;
  assign mdio_cmd_reg   = reg_addr_reg;
  assign mdio_cmd_wdata = wdata_reg;

endmodule

// File: rtl/phy_config_sm.sv
// PHY bring-up sequencer: BMCR write, PHYID1/PHYID2 reads, BMSR read.
// Build option: define PHY_CFG_ID_CHECK_EN to turn PHY-ID mismatches into errors.
module phy_config_sm
  import phy_cfg_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR    = 5'd1,
  parameter logic [15:0] BMCR_CFG    = 16'h6100,
  parameter logic [15:0] PHYID1_EXP  = 16'h2215,
  parameter logic [15:0] PHYID2_EXP  = 16'h1430,
  parameter int          ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_cfg,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        link_up,
  output logic        error,
  output logic        mdio_cmd_valid,
  output logic        mdio_cmd_read,
  output logic [4:0]  mdio_cmd_phy,
  output logic [4:0]  mdio_cmd_reg,
  output logic [15:0] mdio_cmd_wdata,
  input  logic        mdio_busy,
  input  logic        mdio_ack,
  input  logic [15:0] mdio_rdata
);

  localparam state_vec_t ISSUE_MASK = state_bit(ST_WR_BMCR) | state_bit(ST_RD_ID1) |
                                      state_bit(ST_RD_ID2)  | state_bit(ST_RD_BMSR);
  localparam state_vec_t WAIT_MASK  = state_bit(ST_W_BMCR) | state_bit(ST_W_ID1) |
                                      state_bit(ST_W_ID2)  | state_bit(ST_W_BMSR);
  localparam state_vec_t IDLE_MASK  = state_bit(ST_IDLE) | state_bit(ST_DONE) |
                                      state_bit(ST_ERR);

  state_vec_t  state_reg, state_next;
  logic        state_ok;
  logic        issue_req, wait_req;
  logic        issue_fire, ack_seen, ack_timeout;
  logic        cmd_read;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_wdata;
  logic        link_up_reg, link_up_next;
  logic [15:0] phy_id1_reg, phy_id2_reg;
  logic        id1_bad, id2_bad;

  assign state_ok  = is_onehot(state_reg);
  assign issue_req = state_ok & (|(state_reg & ISSUE_MASK));
  assign wait_req  = state_ok & (|(state_reg & WAIT_MASK));

`ifdef PHY_CFG_ID_CHECK_EN
  assign id1_bad = (mdio_rdata != PHYID1_EXP);
  assign id2_bad = (mdio_rdata != PHYID2_EXP);
`else
  assign id1_bad = 1'b0;
  assign id2_bad = 1'b0;
  logic unused_id_exp;
  assign unused_id_exp = ^{PHYID1_EXP, PHYID2_EXP};
`endif

  always_comb begin
    state_next   = state_reg;
    link_up_next = link_up_reg;
    cmd_read     = 1'b1;
    cmd_reg_addr = REG_BMCR;
    cmd_wdata    = '0;
    if (!state_ok) begin
      state_next = state_bit(ST_ERR);
    end else begin
      case (1'b1)
        state_reg[ST_IDLE], state_reg[ST_DONE], state_reg[ST_ERR]: begin
          if (start_cfg) begin
            state_next   = state_bit(ST_WR_BMCR);
            link_up_next = 1'b0;
          end
        end
        state_reg[ST_WR_BMCR]: begin
          cmd_read     = 1'b0;
          cmd_reg_addr = REG_BMCR;
          cmd_wdata    = BMCR_CFG;
          if (issue_fire) state_next = state_bit(ST_W_BMCR);
        end
        state_reg[ST_W_BMCR]: begin
          if (ack_seen)         state_next = state_bit(ST_RD_ID1);
          else if (ack_timeout) state_next = state_bit(ST_ERR);
        end
        state_reg[ST_RD_ID1]: begin
          cmd_reg_addr = REG_PHYID1;
          if (issue_fire) state_next = state_bit(ST_W_ID1);
        end
        state_reg[ST_W_ID1]: begin
          if (ack_seen)         state_next = id1_bad ? state_bit(ST_ERR) : state_bit(ST_RD_ID2);
          else if (ack_timeout) state_next = state_bit(ST_ERR);
        end
        state_reg[ST_RD_ID2]: begin
          cmd_reg_addr = REG_PHYID2;
          if (issue_fire) state_next = state_bit(ST_W_ID2);
        end
        state_reg[ST_W_ID2]: begin
          if (ack_seen)         state_next = id2_bad ? state_bit(ST_ERR) : state_bit(ST_RD_BMSR);
          else if (ack_timeout) state_next = state_bit(ST_ERR);
        end
        state_reg[ST_RD_BMSR]: begin
          cmd_reg_addr = REG_BMSR;
          if (issue_fire) state_next = state_bit(ST_W_BMSR);
        end
        state_reg[ST_W_BMSR]: begin
          if (ack_seen) begin
            state_next   = state_bit(ST_DONE);
            link_up_next = mdio_rdata[BMSR_LINK_BIT];
          end else if (ack_timeout) begin
            state_next = state_bit(ST_ERR);
          end
        end
        default: state_next = state_bit(ST_ERR);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= state_bit(ST_IDLE);
      link_up_reg <= 1'b0;
      phy_id1_reg <= '0;
      phy_id2_reg <= '0;
    end else begin
      state_reg   <= state_next;
      link_up_reg <= link_up_next;
      if (ack_seen && state_reg[ST_W_ID1]) phy_id1_reg <= mdio_rdata;
      if (ack_seen && state_reg[ST_W_ID2]) phy_id2_reg <= mdio_rdata;
    end
  end

  // Captured IDs are kept for debug visibility only
  logic unused_ids;
  assign unused_ids = ^{phy_id1_reg, phy_id2_reg};

  mdio_cmd_issuer #(
    .PHY_ADDR    (PHY_ADDR),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_issuer (
    .clk            (clk),
    .rst_n          (rst_n),
    .issue_req      (issue_req),
    .wait_req       (wait_req),
    .cmd_read       (cmd_read),
    .cmd_reg_addr   (cmd_reg_addr),
    .cmd_wdata      (cmd_wdata),
    .mdio_busy      (mdio_busy),
    .mdio_ack       (mdio_ack),
    .issue_fire     (issue_fire),
    .ack_seen       (ack_seen),
    .ack_timeout    (ack_timeout),
    .mdio_cmd_valid (mdio_cmd_valid),
    .mdio_cmd_read  (mdio_cmd_read),
    .mdio_cmd_phy   (mdio_cmd_phy),
    .mdio_cmd_reg   (mdio_cmd_reg),
    .mdio_cmd_wdata (mdio_cmd_wdata)
  );

  // An illegal pattern shows all-quiet outputs for its one cycle before ERR
  assign cfg_busy = state_ok & (|(state_reg & ~IDLE_MASK));
  assign cfg_done = state_ok & state_reg[ST_DONE];
  assign error    = state_ok & state_reg[ST_ERR];
  assign link_up  = link_up_reg;

endmodule

// File: tb/tb_phy_config_sm.sv
// Self-checking bench for phy_config_sm: MDIO register-file responder plus a
// transaction-level model of the expected command list and final status.
`timescale 1ns/1ps
module tb_phy_config_sm;
  import phy_cfg_pkg::*;

  localparam int          ACK_TO   = 1024;
  localparam logic [15:0] ID1_EXP  = 16'h2215;
  localparam logic [15:0] ID2_EXP  = 16'h1430;
  localparam logic [15:0] BMCR_VAL = 16'h6100;
  localparam logic [4:0]  PHY_A    = 5'd1;
`ifdef PHY_CFG_ID_CHECK_EN
  localparam bit ID_CHECK = 1'b1;
`else
  localparam bit ID_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_cfg = 1'b0;
  logic        mdio_busy = 1'b0;
  logic        mdio_ack = 1'b0;
  logic [15:0] mdio_rdata = '0;
  logic        cfg_busy, cfg_done, link_up, error;
  logic        mdio_cmd_valid, mdio_cmd_read;
  logic [4:0]  mdio_cmd_phy, mdio_cmd_reg;
  logic [15:0] mdio_cmd_wdata;

  phy_config_sm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_cfg      (start_cfg),
    .cfg_busy       (cfg_busy),
    .cfg_done       (cfg_done),
    .link_up        (link_up),
    .error          (error),
    .mdio_cmd_valid (mdio_cmd_valid),
    .mdio_cmd_read  (mdio_cmd_read),
    .mdio_cmd_phy   (mdio_cmd_phy),
    .mdio_cmd_reg   (mdio_cmd_reg),
    .mdio_cmd_wdata (mdio_cmd_wdata),
    .mdio_busy      (mdio_busy),
    .mdio_ack       (mdio_ack),
    .mdio_rdata     (mdio_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Responder state, all updated on the falling edge
  logic [15:0] regfile [32];
  bit          no_ack, busy_rand;
  int          ack_delay, busy_left;
  int          cyc = 0;
  bit          pend = 0;
  int          pend_cnt;
  logic [4:0]  pend_reg;
  logic        pend_read;
  int          cmd_regs[$];
  int          busy_viol, first_valid_cyc, busy_fall_cyc;
  int          bmsr_ack_cyc, done_rise_cyc, err_rise_cyc;
  logic        done_q = 1'b0, err_q = 1'b0, busy_old;

  always @(negedge clk) begin
    cyc++;
    mdio_ack = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (pend_cnt == 0) begin
          mdio_ack   = 1'b1;
          mdio_rdata = pend_read ? regfile[pend_reg] : 16'h0000;
          if (pend_reg == REG_BMSR) bmsr_ack_cyc = cyc;
          chk_val("field_hold", int'(mdio_cmd_reg), int'(pend_reg));
          pend = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (mdio_cmd_valid) begin
        if (mdio_busy) busy_viol++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        cmd_regs.push_back(int'(mdio_cmd_reg));
        $display("cyc %0d: cmd %s reg=%0d phy=%0d wdata=%h", cyc,
                 mdio_cmd_read ? "RD" : "WR", mdio_cmd_reg, mdio_cmd_phy, mdio_cmd_wdata);
        chk_val("cmd_phy", int'(mdio_cmd_phy), int'(PHY_A));
        chk_val("cmd_read", int'(mdio_cmd_read), int'(mdio_cmd_reg != REG_BMCR));
        if (!mdio_cmd_read) begin
          chk_val("cmd_wdata", int'(mdio_cmd_wdata), int'(BMCR_VAL));
          regfile[mdio_cmd_reg] = mdio_cmd_wdata;
        end
        if (!no_ack) begin
          pend      = 1'b1;
          pend_cnt  = ack_delay - 1;
          pend_reg  = mdio_cmd_reg;
          pend_read = mdio_cmd_read;
        end
      end
    end
    if (cfg_done && !done_q) done_rise_cyc = cyc;
    if (error && !err_q)     err_rise_cyc  = cyc;
    done_q   = cfg_done;
    err_q    = error;
    busy_old = mdio_busy;
    if (busy_left > 0) begin
      mdio_busy = 1'b1;
      busy_left--;
    end else begin
      mdio_busy = busy_rand && ($urandom_range(0, 3) == 0);
    end
    if (busy_old && !mdio_busy) busy_fall_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_cfg = 1'b1;
    tick();
    start_cfg = 1'b0;
  endtask

  task automatic prep(input logic [15:0] id1, input logic [15:0] id2, input logic [15:0] bmsr,
                      input int delay, input bit noack, input bit rnd_busy, input int pre_busy);
    for (int i = 0; i < 32; i++) regfile[i] = 16'h0000;
    regfile[REG_BMSR]   = bmsr;
    regfile[REG_PHYID1] = id1;
    regfile[REG_PHYID2] = id2;
    ack_delay = delay;
    no_ack    = noack;
    busy_rand = rnd_busy;
    busy_left = pre_busy;
    cmd_regs.delete();
    busy_viol = 0;
    first_valid_cyc = -1;
    busy_fall_cyc   = -1;
    bmsr_ack_cyc    = -1;
    done_rise_cyc   = -1;
    err_rise_cyc    = -1;
  endtask

  task automatic run_cfg(input logic [15:0] id1, input logic [15:0] id2, input logic [15:0] bmsr,
                         input int delay, input bit noack, input bit rnd_busy, input int pre_busy,
                         input bit restart, input bit chk_fall);
    int  exp_regs[$];
    bit  exp_err, exp_done, exp_link;
    int  n;
    // Reference: the sequence stops at the first failing step
    exp_regs.push_back(int'(REG_BMCR));
    exp_err = 1'b0; exp_done = 1'b0; exp_link = 1'b0;
    if (noack) begin
      exp_err = 1'b1;
    end else begin
      exp_regs.push_back(int'(REG_PHYID1));
      if (ID_CHECK && id1 != ID1_EXP) exp_err = 1'b1;
      else begin
        exp_regs.push_back(int'(REG_PHYID2));
        if (ID_CHECK && id2 != ID2_EXP) exp_err = 1'b1;
        else begin
          exp_regs.push_back(int'(REG_BMSR));
          exp_done = 1'b1;
          exp_link = bmsr[BMSR_LINK_BIT];
        end
      end
    end

    prep(id1, id2, bmsr, delay, noack, rnd_busy, pre_busy);
    pulse_start();
    if (restart) begin
      n = 0;
      while (cmd_regs.size() < 2 && n < 500) begin tick(); n++; end
      chk_val("restart_wait", int'(n < 500), 1);
      pulse_start();
    end
    n = 0;
    while (cfg_busy && n < 5000) begin tick(); n++; end
    chk_val("finish_wait", int'(n < 5000), 1);
    repeat (2) tick();

    chk_val("cmd_count", cmd_regs.size(), exp_regs.size());
    for (int i = 0; i < exp_regs.size() && i < cmd_regs.size(); i++)
      chk_val($sformatf("cmd_reg%0d", i), cmd_regs[i], exp_regs[i]);
    chk_val("cfg_done", int'(cfg_done), int'(exp_done));
    chk_val("error", int'(error), int'(exp_err));
    chk_val("link_up", int'(link_up), int'(exp_link));
    chk_val("cfg_busy", int'(cfg_busy), 0);
    chk_val("bmcr_loopback", int'(regfile[REG_BMCR][BMCR_LOOPBACK_BIT]), 1);
    chk_val("busy_violation", busy_viol, 0);
    if (exp_done) chk_val("done_latency", done_rise_cyc - bmsr_ack_cyc, 1);
    if (noack)    chk_val("timeout_cycles", err_rise_cyc - first_valid_cyc, ACK_TO);
    if (chk_fall) chk_val("busy_release", first_valid_cyc - busy_fall_cyc, 1);
  endtask

  task automatic reset_mid();
    int n, cnt0;
    prep(ID1_EXP, ID2_EXP, 16'h0004, 8, 1'b0, 1'b0, 0);
    pulse_start();
    n = 0;
    while (cmd_regs.size() < 2 && n < 500) begin tick(); n++; end
    chk_val("rst_wait", int'(n < 500), 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk_val("rst_busy", int'(cfg_busy), 0);
    chk_val("rst_done", int'(cfg_done), 0);
    chk_val("rst_error", int'(error), 0);
    chk_val("rst_link", int'(link_up), 0);
    chk_val("rst_valid", int'(mdio_cmd_valid), 0);
    chk_val("rst_fields", int'({mdio_cmd_read, mdio_cmd_phy, mdio_cmd_reg, mdio_cmd_wdata}), 0);
    tick();
    rst_n = 1'b1;
    cnt0 = cmd_regs.size();
    repeat (20) tick();
    chk_val("rst_no_cmd", cmd_regs.size(), cnt0);
    chk_val("rst_idle_busy", int'(cfg_busy), 0);
    chk_val("rst_idle_done", int'(cfg_done), 0);
  endtask

  initial begin
    logic [15:0] r1, r2, rb;
    prep(ID1_EXP, ID2_EXP, 16'h0000, 3, 1'b0, 1'b0, 0);
    repeat (3) tick();
    chk_val("reset_busy", int'(cfg_busy), 0);
    chk_val("reset_done", int'(cfg_done), 0);
    chk_val("reset_error", int'(error), 0);
    chk_val("reset_link", int'(link_up), 0);
    chk_val("reset_valid", int'(mdio_cmd_valid), 0);
    chk_val("reset_fields", int'({mdio_cmd_read, mdio_cmd_phy, mdio_cmd_reg, mdio_cmd_wdata}), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_cfg(ID1_EXP, ID2_EXP, 16'h0004, 3, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run_cfg(ID1_EXP, ID2_EXP, 16'h0000, 3, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_cfg(16'h0000, ID2_EXP, 16'h0004, 3, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_cfg(ID1_EXP, 16'hBEEF, 16'h0004, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_cfg(ID1_EXP, ID2_EXP, 16'h0004, 3, 1'b0, 1'b0, 10, 1'b0, 1'b1);
    run_cfg(ID1_EXP, ID2_EXP, 16'h0004, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      r1 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : ID1_EXP;
      r2 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : ID2_EXP;
      rb = 16'($urandom);
      run_cfg(r1, r2, rb, int'($urandom_range(1, 8)), 1'b0, 1'b1, 0,
              1'($urandom_range(0, 1)), 1'b0);
    end

    reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
